// File: rtl/alu16_op_sequencer.sv
// Command sequencer for the 16-bit one_bit-slice ALU: valid/ready command in, registered ALU drive, response out.
// Build macro ALU_SEQ_SHAMT_EN enables multi-pass shifting (cmd_shamt honoured); undefined means one pass per command.
`timescale 1ns/1ps
module alu16_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic [3:0]       cmd_shamt,
    output logic [4:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_zero_q, rsp_zero_d;

`ifdef ALU_SEQ_SHAMT_EN
    logic [3:0] cnt_q, cnt_d;
`else
    logic unused_shamt;
    assign unused_shamt = ^cmd_shamt;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        rsp_data_d = rsp_data_q;
        rsp_cout_d = rsp_cout_q;
        rsp_zero_d = rsp_zero_q;
`ifdef ALU_SEQ_SHAMT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    sel_d   = cmd_sel;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    cin_d   = cmd_cin;
                    state_d = ST_EXEC;
`ifdef ALU_SEQ_SHAMT_EN
                    cnt_d   = cmd_sel[4] ? cmd_shamt : 4'd1;
`endif
                end
            end
            ST_EXEC: begin
`ifdef ALU_SEQ_SHAMT_EN
                if (cnt_q == 4'd0) begin
                    // Zero-length shift: return the operand untouched, ALU output ignored.
                    rsp_data_d = a_q;
                    rsp_cout_d = 1'b0;
                    rsp_zero_d = (a_q == '0);
                    state_d    = ST_DONE;
                end else begin
                    a_d   = alu_y;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rsp_data_d = alu_y;
                        rsp_cout_d = alu_cout;
                        rsp_zero_d = (alu_y == '0);
                        state_d    = ST_DONE;
                    end
                end
`else
                a_d        = alu_y;
                rsp_data_d = alu_y;
                rsp_cout_d = alu_cout;
                rsp_zero_d = (alu_y == '0);
                state_d    = ST_DONE;
`endif
            end
            ST_DONE: begin
                // No acceptance here even with rsp_ready; the next command waits for IDLE.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_zero_q <= 1'b0;
`ifdef ALU_SEQ_SHAMT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            rsp_data_q <= rsp_data_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_zero_q <= rsp_zero_d;
`ifdef ALU_SEQ_SHAMT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign alu_sel   = sel_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_cin   = cin_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu16_op_sequencer.sv
// Self-checking bench for alu16_op_sequencer with a behavioural ALU and a pass-count reference model.
`timescale 1ns/1ps
module tb_alu16_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_sel;
    logic [15:0] cmd_a, cmd_b;
    logic        cmd_cin;
    logic [3:0]  cmd_shamt;
    logic [4:0]  alu_sel;
    logic [15:0] alu_a, alu_b;
    logic        alu_cin;
    logic [15:0] alu_y;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu16_op_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_shamt(cmd_shamt),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy)
    );

    // Behavioural ALU: returns {cout, y}.
    function automatic logic [16:0] alu_f(input logic [4:0] s, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        logic [16:0] r;
        if (s[4]) begin
            case (s[2:0])
                3'd1:    r = {a[0], c, a[15:1]};
                3'd2:    r = {a[15], a[14:0], a[15]};
                3'd3:    r = {a[0], a[0], a[15:1]};
                default: r = {a[15], a[14:0], c};
            endcase
        end else if (s[3]) begin
            case (s[2:0])
                3'd1:    r = {1'b0, a} + {1'b0, ~b} + {16'd0, c};
                3'd2:    r = {1'b0, a} + 17'd1;
                3'd3:    r = {1'b0, a} + 17'h0FFFF;
                default: r = {1'b0, a} + {1'b0, b} + {16'd0, c};
            endcase
        end else begin
            case (s[2:0])
                3'd0:    r = {1'b0, a & b};
                3'd1:    r = {1'b0, a | b};
                3'd2:    r = {1'b0, a ^ b};
                3'd3:    r = {1'b0, ~(a & b)};
                3'd4:    r = {1'b0, ~(a | b)};
                3'd5:    r = {1'b0, ~(a ^ b)};
                3'd6:    r = {1'b0, ~a};
                default: r = {1'b0, a};
            endcase
        end
        return r;
    endfunction

    assign {alu_cout, alu_y} = alu_f(alu_sel, alu_a, alu_b, alu_cin);

    function automatic int npasses(input logic [4:0] s, input logic [3:0] sh);
        int n;
        n = 1;
`ifdef ALU_SEQ_SHAMT_EN
        if (s[4]) n = int'(sh);
`else
        if (s[4] && sh == 4'd0) n = 1;
`endif
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [4:0] s, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic [3:0] sh, input int hold);
        int          k, lat;
        logic [15:0] ey, prev_y, held_a, held_d;
        logic        ec;
        logic [16:0] r;
        k  = npasses(s, sh);
        ey = a;
        ec = 1'b0;
        for (int i = 0; i < k; i++) begin
            r  = alu_f(s, ey, b, c);
            ey = r[15:0];
            ec = r[16];
        end
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_cin = c; cmd_shamt = sh;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_sel = 5'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        cmd_cin = 1'($urandom); cmd_shamt = 4'($urandom);
        chk("alu_sel", 32'(alu_sel), 32'(s));
        chk("alu_a", 32'(alu_a), 32'(a));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("alu_cin", 32'(alu_cin), 32'(c));
        chk("busy_exec", 32'(busy), 32'd1);
        lat    = 0;
        prev_y = alu_y;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat <= k) chk("alu_a_feedback", 32'(alu_a), 32'(prev_y));
            chk("alu_b_const", 32'(alu_b), 32'(b));
            prev_y = alu_y;
        end
        chk("latency", 32'(lat), 32'((k < 1) ? 1 : k));
        chk("rsp_data", 32'(rsp_data), 32'(ey));
        chk("rsp_cout", 32'(rsp_cout), 32'(ec));
        chk("rsp_zero", 32'(rsp_zero), 32'(ey == 16'd0));
        $display("cmd sel=%b a=%h b=%h cin=%0d shamt=%0d -> data=%h cout=%0d zero=%0d lat=%0d",
                 s, a, b, c, sh, rsp_data, rsp_cout, rsp_zero, lat);
        cmd_valid = 1'b1;
        cmd_sel = 5'($urandom); cmd_a = 16'($urandom); cmd_shamt = 4'($urandom);
        held_a = alu_a;
        held_d = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(held_d));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_alu_a", 32'(alu_a), 32'(held_a));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("release_valid", 32'(rsp_valid), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
        chk("no_accept_in_done", 32'(alu_a), 32'(held_a));
        cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_cout"}, 32'(rsp_cout), 32'd0);
        chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
        chk({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        chk({tag, "_alu_cin"}, 32'(alu_cin), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0;
        cmd_cin = 1'b0; cmd_shamt = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("after_reset");

        run_cmd(5'b01000, 16'h00FF, 16'h0001, 1'b0, 4'd0, 0);
        run_cmd(5'b10000, 16'h0001, 16'h0000, 1'b0, 4'd4, 0);
        run_cmd(5'b10000, 16'hA5A5, 16'h0000, 1'b0, 4'd0, 1);
        run_cmd(5'b01001, 16'h1234, 16'h1234, 1'b1, 4'd3, 5);
        run_cmd(5'b10000, 16'h8001, 16'h0000, 1'b1, 4'd7, 0);
        run_cmd(5'b10010, 16'hC003, 16'h0000, 1'b0, 4'd15, 2);

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_sel = 5'b10001; cmd_a = 16'hF0F0; cmd_b = 16'h0F0F;
        cmd_cin = 1'b1; cmd_shamt = 4'd10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        end
        $display("reset mid-shift -> idle, no response");

        for (int i = 0; i < 24; i++) begin
            run_cmd(5'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                    4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
